hour_counter: RTL and testbench
===============================

# hour_counter

Hour stage of the alarm-clock timekeeping chain, directly downstream of the minute counter. Advances on the minute counter's one-cycle carry, keeps a 0–23 hour internally and presents it as 24-hour or 12-hour with AM/PM. Also accepts a raw "set hour" pushbutton, which it synchronises, debounces and auto-repeats. Emits a one-cycle day carry on midnight rollover.

## Interface
- `DEB_CYCLES`, 20: cycles `btn_raw` must stay high (after synchronisation) before the first increment.
- `HOLD_CYCLES`, 500: cycles from the first button increment to the first auto-repeat increment.
- `RPT_CYCLES`, 200: cycles between subsequent auto-repeat increments.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `c`  in  1  minute carry; one hour increment per clock cycle it is sampled high.
- `btn_raw`  in  1  unsynchronised, bouncy set-hour button, active-high.
- `mode24`  in  1  1 = 24-hour display, 0 = 12-hour display.
- `count`  out  5  displayed hour.
- `pm`  out  1  high when internal hour is 12–23.
- `zC`  out  1  day carry, a one-cycle pulse.

## Operation
- Internal register `h24`, range 0–23. Reset value is 0.
- Each rising edge, `h24` advances by `c + btn_inc`, modulo 24. When both sources are active in the same cycle, `h24` advances by 2 (e.g. 22 → 0, 23 → 1).
- `zC` is registered. It is set for exactly one cycle at the edge where `c==1` and `h24==23` before update. A button-only wrap does not assert `zC`.
- Output mapping:
  - `mode24=1`: `count = h24`.
  - `mode24=0`: `count = h24 mod 12`, with 0 shown as 12 (range 1–12).
  - `pm = (h24 >= 12)` in both modes.
  - `count` and `pm` are combinational from `h24` and `mode24`; a `mode24` change is visible in the same cycle.
- Button path: `btn_raw` passes through a 2-FF synchroniser to give `bs`.
- FSM with states IDLE, DEB, HELD, RPT and a shared down-counter/up-counter `tcnt`:
  - IDLE: `bs=1` → DEB, `tcnt=0`.
  - DEB: `bs=0` → IDLE. When `tcnt==DEB_CYCLES-1`, `btn_inc=1` this cycle, then → HELD, `tcnt=0`.
  - HELD: `bs=0` → IDLE. When `tcnt==HOLD_CYCLES-1`, `btn_inc=1`, then → RPT, `tcnt=0`.
  - RPT: `bs=0` → IDLE. When `tcnt==RPT_CYCLES-1`, `btn_inc=1`, `tcnt=0`, and stay in RPT.
  - Otherwise `tcnt` increments.
- `btn_inc` is combinational from state, `tcnt` and `bs`. Release (`bs=0`) takes priority over any pending increment.
- A bounce shorter than `DEB_CYCLES` produces no increment.
- `rst` mid-operation immediately clears `h24`, `zC`, the FSM (to IDLE), `tcnt` and both synchroniser flops.
- Reset values of the outputs:
  - `mode24=1`: `count=0`.
  - `mode24=0`: `count=12`.
  - `pm=0`, `zC=0`.

## Timing
- `c` to `count`: 1 edge. `h24` updates on the edge that samples `c=1`.
- `c` to `zC`: high during the cycle following the sampling edge.
- Button latency: let edge 1 be the first edge to sample `btn_raw=1`. `bs` is high after edge 2, the FSM enters DEB at edge 3, and `h24` increments at edge `DEB_CYCLES+3`.
- Auto-repeat while held:
  - First repeat increment is `HOLD_CYCLES` edges after the first increment.
  - Each further increment follows `RPT_CYCLES` edges after the previous one.
- Release latency: `btn_raw` low at edge n gives `bs` low after edge n+1. An increment that would occur at edge n+2 is suppressed.

## Configuration
- `HOUR_AMPM_EN` defined:
  - 12/24-hour mapping and `pm` behave as described above.
- `HOUR_AMPM_EN` undefined:
  - `mode24` is ignored.
  - `count = h24` always.
  - `pm` is tied to 0.
  - Port list is unchanged.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `h24=15` → `count=0`, `pm=0` and `zC=0` immediately (`mode24=1`); deassert → hold 0.
- Rollover: preload to 23 via 23 `c` pulses, then one `c` pulse → `count=0`, `zC=1` for exactly one cycle, then `zC=0`.
- 12-hour mapping (`HOUR_AMPM_EN`, `mode24=0`):
  - `h24` = 0, 11, 12, 13, 23 → `count` = 12, 11, 12, 1, 11.
  - `pm` = 0, 0, 1, 1, 1.
- Debounce: bounce `btn_raw` high 10 cycles, low 3, then hold high (DEB_CYCLES=20) → exactly one increment, at edge 23 after the final rise; no increment from the 10-cycle bounce.
- Auto-repeat: hold `btn_raw` high for 20+3+500+2×200 cycles from `h24=0` → `h24=4`; release → no further increments.
- Simultaneous: `c=1` on the same edge as the first button increment at `h24=23` → `h24=1`, `zC=1`. Same case at `h24=22` → `h24=0`, `zC=0`.

Source files
------------

// File: rtl/hour_counter.sv
// ============================================================================
// hour_counter
// ----------------------------------------------------------------------------
// Hour stage of the alarm-clock timekeeping chain. It sits after the minute
// counter and keeps a 0-23 hour. The hour advances on the minute carry and on
// a debounced, auto-repeating "set hour" pushbutton. The hour is shown in
// 24-hour form, or in 12-hour form with an AM/PM flag. A one-cycle day carry
// is emitted on midnight rollover caused by the minute carry.
//
// Build option:
//   HOUR_AMPM_EN  defined   -> 12/24-hour display mapping and pm flag active
//                 undefined -> mode24 ignored, count = hour, pm tied to 0
//
// Parameters:
//   DEB_CYCLES   cycles the synchronised button must stay high before the
//                first increment
//   HOLD_CYCLES  cycles from the first button increment to the first repeat
//   RPT_CYCLES   cycles between later auto-repeat increments
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   c        in   minute carry; one hour increment per cycle sampled high
//   btn_raw  in   unsynchronised, bouncy set-hour button, active-high
//   mode24   in   1 = 24-hour display, 0 = 12-hour display
//   count    out  displayed hour (combinational from the hour and mode24)
//   pm       out  high when the hour is 12-23 (combinational)
//   zC       out  registered day carry, one-cycle pulse
// ============================================================================
module hour_counter #(
    parameter int unsigned DEB_CYCLES  = 20,
    parameter int unsigned HOLD_CYCLES = 500,
    parameter int unsigned RPT_CYCLES  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c,
    input  logic       btn_raw,
    input  logic       mode24,
    output logic [4:0] count,
    output logic       pm,
    output logic       zC
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int unsigned H_W     = 5;
    localparam int unsigned SUM_W   = H_W + 1;
    localparam int unsigned MAX_DH  = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_DH > RPT_CYCLES) ? MAX_DH : RPT_CYCLES;
    localparam int unsigned TCNT_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TCNT_W-1:0] DEB_LAST  = TCNT_W'(DEB_CYCLES - 1);
    localparam logic [TCNT_W-1:0] HOLD_LAST = TCNT_W'(HOLD_CYCLES - 1);
    localparam logic [TCNT_W-1:0] RPT_LAST  = TCNT_W'(RPT_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_ZERO = TCNT_W'(0);

    localparam logic [H_W-1:0]   HOUR_LAST = H_W'(23);
    localparam logic [H_W-1:0]   HOUR_NOON = H_W'(12);
    localparam logic [SUM_W-1:0] HOURS_DAY = SUM_W'(24);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEB  = 2'd1,
        S_HELD = 2'd2,
        S_RPT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic              r_sync_meta;
    logic              r_bs;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [TCNT_W-1:0] r_tcnt;
    logic [TCNT_W-1:0] w_tcnt_nxt;
    logic              w_btn_inc;
    logic [H_W-1:0]    r_h24;
    logic [H_W-1:0]    w_h24_nxt;
    logic [SUM_W-1:0]  w_h24_sum;
    logic              r_zc;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser for the raw button
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_bs        <= 1'b0;
        end else begin
            r_sync_meta <= btn_raw;
            r_bs        <= r_sync_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Button FSM: state and shared interval counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tcnt  <= TCNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Button FSM: next state and counter; release always wins over an
    // interval expiring in the same cycle
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        case (r_state)
            S_IDLE: begin
                if (r_bs) begin
                    w_state_nxt = S_DEB;
                    w_tcnt_nxt  = TCNT_ZERO;
                end
            end
            S_DEB: begin
                if (!r_bs) begin
                    w_state_nxt = S_IDLE;
                    w_tcnt_nxt  = TCNT_ZERO;
                end else if (r_tcnt == DEB_LAST) begin
                    w_state_nxt = S_HELD;
                    w_tcnt_nxt  = TCNT_ZERO;
                end else begin
                    w_tcnt_nxt  = r_tcnt + TCNT_W'(1);
                end
            end
            S_HELD: begin
                if (!r_bs) begin
                    w_state_nxt = S_IDLE;
                    w_tcnt_nxt  = TCNT_ZERO;
                end else if (r_tcnt == HOLD_LAST) begin
                    w_state_nxt = S_RPT;
                    w_tcnt_nxt  = TCNT_ZERO;
                end else begin
                    w_tcnt_nxt  = r_tcnt + TCNT_W'(1);
                end
            end
            S_RPT: begin
                if (!r_bs) begin
                    w_state_nxt = S_IDLE;
                    w_tcnt_nxt  = TCNT_ZERO;
                end else if (r_tcnt == RPT_LAST) begin
                    w_tcnt_nxt  = TCNT_ZERO;
                end else begin
                    w_tcnt_nxt  = r_tcnt + TCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tcnt_nxt  = TCNT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Button FSM: increment strobe on the last cycle of each interval
    // ------------------------------------------------------------------------
    always_comb begin
        w_btn_inc = 1'b0;
        case (r_state)
            S_DEB:   w_btn_inc = r_bs && (r_tcnt == DEB_LAST);
            S_HELD:  w_btn_inc = r_bs && (r_tcnt == HOLD_LAST);
            S_RPT:   w_btn_inc = r_bs && (r_tcnt == RPT_LAST);
            default: w_btn_inc = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Hour arithmetic: advance by c + btn_inc (0..2), modulo 24
    // ------------------------------------------------------------------------
    always_comb begin
        w_h24_sum = SUM_W'(r_h24) + SUM_W'(c) + SUM_W'(w_btn_inc);
        if (w_h24_sum >= HOURS_DAY) begin
            w_h24_nxt = H_W'(w_h24_sum - HOURS_DAY);
        end else begin
            w_h24_nxt = H_W'(w_h24_sum);
        end
    end

    // ------------------------------------------------------------------------
    // Hour register and day carry; only the minute carry at 23 makes a day
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h24 <= '0;
            r_zc  <= 1'b0;
        end else begin
            r_h24 <= w_h24_nxt;
            r_zc  <= c && (r_h24 == HOUR_LAST);
        end
    end

    assign zC = r_zc;

    // ------------------------------------------------------------------------
    // Display mapping
    // ------------------------------------------------------------------------
`ifdef HOUR_AMPM_EN
    logic [H_W-1:0] w_h12;

    // 12-hour form: hour mod 12, with 0 shown as 12
    always_comb begin
        pm = (r_h24 >= HOUR_NOON);
        if (pm) begin
            w_h12 = r_h24 - HOUR_NOON;
        end else begin
            w_h12 = r_h24;
        end
        if (w_h12 == H_W'(0)) begin
            w_h12 = HOUR_NOON;
        end
        count = mode24 ? r_h24 : w_h12;
    end
`else
    logic w_unused_mode24;

    // Fixed 24-hour display; mode24 has no effect in this build
    assign w_unused_mode24 = mode24;
    assign count           = r_h24;
    assign pm              = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Sanity checks on internal state
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_hour_range: assert property (@(posedge clk) disable iff (rst)
        r_h24 <= HOUR_LAST);
    a_zc_single: assert property (@(posedge clk) disable iff (rst)
        r_zc |=> !r_zc);
`endif

endmodule

// File: tb/tb_hour_counter.sv
module tb_hour_counter;

`ifdef HOUR_AMPM_EN
    localparam bit AMPM = 1'b1;
`else
    localparam bit AMPM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       c;
    logic       btn_raw;
    logic       mode24;
    logic [4:0] count;
    logic       pm;
    logic       zC;

    always #5 clk = ~clk;

    hour_counter dut (
        .clk     (clk),
        .rst     (rst),
        .c       (c),
        .btn_raw (btn_raw),
        .mode24  (mode24),
        .count   (count),
        .pm      (pm),
        .zC      (zC)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard: one expected output set per entry, consumed at the next
    // falling edge
    string      q_name[$];
    logic [4:0] q_cnt[$];
    logic       q_pm[$];
    logic       q_zc[$];

    function automatic logic e_pm(input int h);
        return (h >= 12) && AMPM;
    endfunction

    task automatic expect_out(input string n, input logic [4:0] ec,
                              input logic ep, input logic ez);
        q_name.push_back(n);
        q_cnt.push_back(ec);
        q_pm.push_back(ep);
        q_zc.push_back(ez);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // c held high for n consecutive sampling edges
    task automatic c_pulses(input int n);
        c = 1'b1;
        tick_n(n);
        c = 1'b0;
    endtask

    task automatic btn_cycles(input logic v, input int n);
        btn_raw = v;
        tick_n(n);
    endtask

    // Monitor: compares the DUT outputs against the oldest expectation
    initial begin
        string      n;
        logic [4:0] ec;
        logic       ep;
        logic       ez;
        forever begin
            @(negedge clk);
            if (q_name.size() > 0) begin
                n  = q_name.pop_front();
                ec = q_cnt.pop_front();
                ep = q_pm.pop_front();
                ez = q_zc.pop_front();
                checks++;
                if (count !== ec || pm !== ep || zC !== ez) begin
                    errors++;
                    $display("FAIL %s: got count=%0d pm=%0b zC=%0b, want count=%0d pm=%0b zC=%0b",
                             n, count, pm, zC, ec, ep, ez);
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        c       = 1'b0;
        btn_raw = 1'b0;
        mode24  = 1'b1;

        // Reset state
        tick();
        expect_out("rst_init", 5'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick_n(3);
        expect_out("rst_hold", 5'd0, 1'b0, 1'b0);

        // Count to 15, then asynchronous reset in the middle of a cycle
        c_pulses(15);
        expect_out("h15", 5'd15, e_pm(15), 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        expect_out("rst_async", 5'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick_n(2);
        expect_out("rst_after", 5'd0, 1'b0, 1'b0);

        // Midnight rollover from the minute carry
        c_pulses(23);
        expect_out("pre_roll", 5'd23, e_pm(23), 1'b0);
        c_pulses(1);
        expect_out("roll", 5'd0, 1'b0, 1'b1);
        tick();
        expect_out("roll_next", 5'd0, 1'b0, 1'b0);

        // 12-hour mapping (plain hour when the AM/PM build option is off)
        tick();
        mode24 = 1'b0;
        expect_out("m12_h0", AMPM ? 5'd12 : 5'd0, 1'b0, 1'b0);
        c_pulses(11);
        expect_out("m12_h11", 5'd11, 1'b0, 1'b0);
        c_pulses(1);
        expect_out("m12_h12", 5'd12, AMPM, 1'b0);
        c_pulses(1);
        expect_out("m12_h13", AMPM ? 5'd1 : 5'd13, AMPM, 1'b0);
        c_pulses(10);
        expect_out("m12_h23", AMPM ? 5'd11 : 5'd23, AMPM, 1'b0);
        tick();
        mode24 = 1'b1;
        expect_out("m24_h23", 5'd23, AMPM, 1'b0);

        // Reset seen in 12-hour mode
        tick();
        mode24 = 1'b0;
        rst    = 1'b1;
        expect_out("rst_m12", AMPM ? 5'd12 : 5'd0, 1'b0, 1'b0);
        tick();
        rst    = 1'b0;
        mode24 = 1'b1;
        tick_n(2);

        // Debounce: 10-cycle bounce, 3 low, then held; increment at edge 23
        btn_cycles(1'b1, 10);
        expect_out("bounce_hi", 5'd0, 1'b0, 1'b0);
        btn_cycles(1'b0, 3);
        btn_cycles(1'b1, 22);
        expect_out("deb_e22", 5'd0, 1'b0, 1'b0);
        tick();
        expect_out("deb_e23", 5'd1, 1'b0, 1'b0);
        btn_raw = 1'b0;
        tick_n(40);
        expect_out("deb_release", 5'd1, 1'b0, 1'b0);

        // Auto-repeat: increments at edges 23, 523, 723, 923
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick_n(2);
        btn_cycles(1'b1, 22);
        expect_out("ar_e22", 5'd0, 1'b0, 1'b0);
        tick();
        expect_out("ar_e23", 5'd1, 1'b0, 1'b0);
        tick_n(499);
        expect_out("ar_e522", 5'd1, 1'b0, 1'b0);
        tick();
        expect_out("ar_e523", 5'd2, 1'b0, 1'b0);
        tick_n(199);
        expect_out("ar_e722", 5'd2, 1'b0, 1'b0);
        tick();
        expect_out("ar_e723", 5'd3, 1'b0, 1'b0);
        tick_n(199);
        expect_out("ar_e922", 5'd3, 1'b0, 1'b0);
        tick();
        expect_out("ar_e923", 5'd4, 1'b0, 1'b0);
        btn_raw = 1'b0;
        tick_n(2);
        expect_out("ar_e925", 5'd4, 1'b0, 1'b0);
        tick_n(300);
        expect_out("ar_idle", 5'd4, 1'b0, 1'b0);

        // Carry and first button increment on the same edge, from 23
        c_pulses(19);
        expect_out("sim_pre23", 5'd23, e_pm(23), 1'b0);
        btn_cycles(1'b1, 22);
        c = 1'b1;
        tick();
        c       = 1'b0;
        btn_raw = 1'b0;
        expect_out("sim_23", 5'd1, 1'b0, 1'b1);
        tick();
        expect_out("sim_23_next", 5'd1, 1'b0, 1'b0);

        // Same, from 22: wraps to 0 without a day carry
        c_pulses(21);
        expect_out("sim_pre22", 5'd22, e_pm(22), 1'b0);
        btn_cycles(1'b1, 22);
        c = 1'b1;
        tick();
        c       = 1'b0;
        btn_raw = 1'b0;
        expect_out("sim_22", 5'd0, 1'b0, 1'b0);
        tick();
        expect_out("sim_22_next", 5'd0, 1'b0, 1'b0);

        // Let the monitor drain, bounded
        tick_n(3);
        if (q_name.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q_name.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
